// File: rtl/ram_burst_writer.sv
// ram_burst_writer: streams a burst of upstream words into consecutive RAM
// write addresses (modulo 2^AW), one registered write per accepted beat.
// Ports: clk, rst_n (async active-low); command start/base_addr/len_m1/abort;
// stream s_valid/s_data/s_ready; RAM ram_we/ram_waddr/ram_di;
// status busy/done/cmd_err.
// Build option: RAM_BURST_WRITER_CKSUM_EN adds output cksum (sum of burst).
module ram_burst_writer #(
    parameter int AW = 8,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [AW-1:0] base_addr,
    input  logic [AW-1:0] len_m1,
    input  logic          abort,
    input  logic          s_valid,
    input  logic [DW-1:0] s_data,
    output logic          s_ready,
    output logic          ram_we,
    output logic [AW-1:0] ram_waddr,
    output logic [DW-1:0] ram_di,
    output logic          busy,
    output logic          done,
    output logic          cmd_err
`ifdef RAM_BURST_WRITER_CKSUM_EN
    ,
    output logic [DW-1:0] cksum
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic          w_ready;
    logic          w_beat;
    logic          w_accept;
    logic [AW-1:0] r_addr;
    logic [AW-1:0] r_rem;
    logic          r_we;
    logic [AW-1:0] r_waddr;
    logic [DW-1:0] r_di;
    logic          r_cmd_err;

    always_comb begin
        w_next  = r_state;
        w_ready = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (start) w_next = S_RUN;
            end
            S_RUN: begin
                // abort masks the beat in the same cycle
                if (abort) begin
                    w_next = S_IDLE;
                end else begin
                    w_ready = 1'b1;
                    if (s_valid && (r_rem == '0)) w_next = S_DONE;
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    assign w_beat   = w_ready && s_valid;
    assign w_accept = (r_state == S_IDLE) && start;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_addr    <= '0;
            r_rem     <= '0;
            r_we      <= 1'b0;
            r_waddr   <= '0;
            r_di      <= '0;
            r_cmd_err <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_we      <= w_beat;
            r_cmd_err <= start && (r_state != S_IDLE);
            if (w_accept) begin
                r_addr <= base_addr;
                r_rem  <= len_m1;
            end else if (w_beat) begin
                r_addr  <= r_addr + AW'(1);
                r_rem   <= r_rem - AW'(1);
                r_waddr <= r_addr;
                r_di    <= s_data;
            end
        end
    end

`ifdef RAM_BURST_WRITER_CKSUM_EN
    logic [DW-1:0] r_sum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum <= '0;
        end else if (w_accept) begin
            r_sum <= '0;
        end else if (w_beat) begin
            r_sum <= r_sum + s_data;
        end
    end

    assign cksum = r_sum;
`endif

    // DONE is entered on the edge that registers the last write,
    // so done lines up with the final ram_we.
    assign s_ready   = w_ready;
    assign ram_we    = r_we;
    assign ram_waddr = r_waddr;
    assign ram_di    = r_di;
    assign busy      = (r_state != S_IDLE);
    assign done      = (r_state == S_DONE);
    assign cmd_err   = r_cmd_err;

endmodule
